// File: rtl/spi_raid_target_pkg.sv
// Shared constants for the SPI RAID member-disk target: opcodes, FSM state codes,
// status-byte bit positions and the opcode decoder.
package spi_raid_target_pkg;

  localparam logic [7:0] OP_READ   = 8'h03;
  localparam logic [7:0] OP_WRITE  = 8'h02;
  localparam logic [7:0] OP_STATUS = 8'h05;
  localparam logic [7:0] OP_ID     = 8'h9F;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_CMD    = 3'd1;
  localparam logic [2:0] ST_ADDR   = 3'd2;
  localparam logic [2:0] ST_RD     = 3'd3;
  localparam logic [2:0] ST_WR     = 3'd4;
  localparam logic [2:0] ST_STAT   = 3'd5;
  localparam logic [2:0] ST_ID     = 3'd6;
  localparam logic [2:0] ST_IGNORE = 3'd7;

  localparam int STAT_WR_SEEN  = 0;
  localparam int STAT_ERR_SEEN = 1;
  localparam int STAT_WP       = 2;

  function automatic logic [2:0] decode_opcode(input logic [7:0] op);
    case (op)
      OP_READ, OP_WRITE: return ST_ADDR;
      OP_STATUS:         return ST_STAT;
      OP_ID:             return ST_ID;
      default:           return ST_IGNORE;
    endcase
  endfunction

endpackage

// File: rtl/spi_raid_target_sync.sv
// Two-flop synchroniser for one asynchronous SPI pin, with rise/fall strobes
// derived from the synchronised value and its one-cycle delay.
module spi_raid_target_sync #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic q,
  output logic rise,
  output logic fall
);

  logic meta_q;
  logic sync_q;
  logic dly_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
      dly_q  <= RST_VAL;
    end else begin
      meta_q <= din;
      sync_q <= meta_q;
      dly_q  <= sync_q;
    end
  end

  assign q    = sync_q;
  assign rise = sync_q & ~dly_q;
  assign fall = ~sync_q & dly_q;

endmodule

// File: rtl/spi_raid_target.sv
// SPI mode-0 target modelling one RAID member disk (READ/WRITE/STATUS/ID over a
// small byte memory). Define SPI_RAID_TARGET_WPROT_EN to add the wp_i write-protect pin.
module spi_raid_target
  import spi_raid_target_pkg::*;
#(
  parameter int         ADDR_W  = 8,
  parameter logic [7:0] ID_BYTE = 8'hA5
) (
  input  logic       wb_clk_i,
  input  logic       wb_rst_i,
  input  logic       spi_clk,
  input  logic       spi_cs,
  input  logic       spi_mosi,
`ifdef SPI_RAID_TARGET_WPROT_EN
  input  logic       wp_i,
`endif
  output logic       spi_miso,
  output logic       busy_o,
  output logic       wr_pulse_o,
  output logic       frame_err_o,
  output logic [2:0] dbg_state_o
);

  localparam int DEPTH = 1 << ADDR_W;

  logic sclk_q_unused, sclk_rise, sclk_fall;
  logic cs_q, cs_rise, cs_fall;
  logic mosi_q, mosi_rise_unused, mosi_fall_unused;
  logic wp_q;

  // cs idles high, so its synchroniser resets high to avoid a phantom frame.
  spi_raid_target_sync #(.RST_VAL(1'b0)) u_sync_clk (
    .clk(wb_clk_i), .rst(wb_rst_i), .din(spi_clk),
    .q(sclk_q_unused), .rise(sclk_rise), .fall(sclk_fall));
  spi_raid_target_sync #(.RST_VAL(1'b1)) u_sync_cs (
    .clk(wb_clk_i), .rst(wb_rst_i), .din(spi_cs),
    .q(cs_q), .rise(cs_rise), .fall(cs_fall));
  spi_raid_target_sync #(.RST_VAL(1'b0)) u_sync_mosi (
    .clk(wb_clk_i), .rst(wb_rst_i), .din(spi_mosi),
    .q(mosi_q), .rise(mosi_rise_unused), .fall(mosi_fall_unused));

`ifdef SPI_RAID_TARGET_WPROT_EN
  logic wp_rise_unused, wp_fall_unused;
  spi_raid_target_sync #(.RST_VAL(1'b0)) u_sync_wp (
    .clk(wb_clk_i), .rst(wb_rst_i), .din(wp_i),
    .q(wp_q), .rise(wp_rise_unused), .fall(wp_fall_unused));
`else
  assign wp_q = 1'b0;
`endif

  logic [2:0]        state;
  logic [2:0]        bit_cnt;
  logic [7:0]        shift_in;
  logic [7:0]        shift_out;
  logic [ADDR_W-1:0] ptr;
  logic              cmd_rd;
  logic              wr_seen;
  logic              err_seen;
  logic [7:0]        mem [DEPTH];

  logic [7:0]        byte_in;
  logic [7:0]        status;
  logic [ADDR_W-1:0] ptr_next;
  logic [ADDR_W-1:0] addr_in;
  logic              byte_done;
  logic              mem_we;

  assign byte_in  = {shift_in[6:0], mosi_q};
  assign ptr_next = ptr + 1'b1;
  assign addr_in  = byte_in[ADDR_W-1:0];

  // A clk edge coinciding with any cs edge is dropped: cs always wins.
  assign byte_done = (state != ST_IDLE) && !cs_rise && !cs_fall &&
                     sclk_rise && (bit_cnt == 3'd7);
  assign mem_we    = !wb_rst_i && byte_done && (state == ST_WR) && !wp_q;

  always_comb begin
    status = 8'h00;
    status[STAT_WR_SEEN]  = wr_seen;
    status[STAT_ERR_SEEN] = err_seen;
    status[STAT_WP]       = wp_q;
  end

  always_ff @(posedge wb_clk_i) begin
    if (mem_we) mem[ptr] <= byte_in;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state       <= ST_IDLE;
      bit_cnt     <= 3'd0;
      shift_in    <= 8'h00;
      shift_out   <= 8'h00;
      ptr         <= '0;
      cmd_rd      <= 1'b0;
      wr_seen     <= 1'b0;
      err_seen    <= 1'b0;
      spi_miso    <= 1'b0;
      wr_pulse_o  <= 1'b0;
      frame_err_o <= 1'b0;
    end else begin
      wr_pulse_o  <= 1'b0;
      frame_err_o <= 1'b0;
      if (cs_rise) begin
        state    <= ST_IDLE;
        spi_miso <= 1'b0;
        bit_cnt  <= 3'd0;
        if (bit_cnt != 3'd0) begin
          frame_err_o <= 1'b1;
          err_seen    <= 1'b1;
        end else if (state == ST_STAT) begin
          err_seen <= 1'b0;
        end
      end else if (cs_fall) begin
        state     <= ST_CMD;
        bit_cnt   <= 3'd0;
        shift_out <= 8'h00;
        spi_miso  <= 1'b0;
      end else if (state != ST_IDLE) begin
        if (sclk_rise) begin
          shift_in <= byte_in;
          bit_cnt  <= bit_cnt + 3'd1;
          // On a byte boundary, preload the byte to shift out next.
          if (byte_done) begin
            case (state)
              ST_CMD: begin
                state     <= decode_opcode(byte_in);
                cmd_rd    <= (byte_in == OP_READ);
                shift_out <= (byte_in == OP_STATUS) ? status :
                             (byte_in == OP_ID)     ? ID_BYTE : 8'h00;
              end
              ST_ADDR: begin
                ptr       <= addr_in;
                state     <= cmd_rd ? ST_RD : ST_WR;
                shift_out <= cmd_rd ? mem[addr_in] : 8'h00;
              end
              ST_RD: begin
                ptr       <= ptr_next;
                shift_out <= mem[ptr_next];
              end
              ST_WR: begin
                ptr       <= ptr_next;
                shift_out <= 8'h00;
                if (!wp_q) begin
                  wr_pulse_o <= 1'b1;
                  wr_seen    <= 1'b1;
                end
              end
              ST_STAT: shift_out <= status;
              ST_ID:   shift_out <= ID_BYTE;
              default: shift_out <= 8'h00;
            endcase
          end
        end else if (sclk_fall) begin
          spi_miso  <= shift_out[7];
          shift_out <= {shift_out[6:0], 1'b0};
        end
      end
    end
  end

  assign busy_o      = ~cs_q;
  assign dbg_state_o = state;

endmodule

// File: tb/tb_spi_raid_target.sv
// Directed bench for spi_raid_target: an SPI mode-0 master driver, an expected-MISO
// queue, pulse monitors and a final report.
module tb_spi_raid_target;
  import spi_raid_target_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       spi_clk = 1'b0;
  logic       spi_cs = 1'b1;
  logic       spi_mosi = 1'b0;
  logic       spi_miso;
  logic       busy_o;
  logic       wr_pulse_o;
  logic       frame_err_o;
  logic [2:0] dbg_state_o;
`ifdef SPI_RAID_TARGET_WPROT_EN
  logic       wp_i = 1'b0;
`endif

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;
  int ferr_cnt = 0;
  logic [7:0] exp_q[$];

  spi_raid_target #(.ADDR_W(8), .ID_BYTE(8'hA5)) dut (
    .wb_clk_i(clk),
    .wb_rst_i(rst),
    .spi_clk(spi_clk),
    .spi_cs(spi_cs),
    .spi_mosi(spi_mosi),
`ifdef SPI_RAID_TARGET_WPROT_EN
    .wp_i(wp_i),
`endif
    .spi_miso(spi_miso),
    .busy_o(busy_o),
    .wr_pulse_o(wr_pulse_o),
    .frame_err_o(frame_err_o),
    .dbg_state_o(dbg_state_o)
  );

  // clock / monitors
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (wr_pulse_o) wr_cnt <= wr_cnt + 1;
    if (frame_err_o) ferr_cnt <= ferr_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver tasks: SPI phases are 50 ns (5 system clocks), edges kept off posedge clk
  task automatic cs_low();
    @(negedge clk);
    #2 spi_cs = 1'b0;
    #50;
  endtask

  task automatic cs_high();
    #50 spi_cs = 1'b1;
    #100;
  endtask

  task automatic xfer_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 7; i > 7 - n; i--) begin
      spi_mosi = tx[i];
      #50 spi_clk = 1'b1;
      rx[i] = spi_miso;
      #50 spi_clk = 1'b0;
    end
  endtask

  // scoreboard: expected MISO byte queued as the byte is driven, compared on receipt
  task automatic xfer(input string tag, input logic [7:0] tx, input logic [7:0] exp);
    logic [7:0] rx;
    logic [7:0] e;
    exp_q.push_back(exp);
    xfer_bits(tx, 8, rx);
    e = exp_q.pop_front();
    chk(tag, rx, e);
  endtask

  initial begin : main
    int w0;
    int f0;
    logic [7:0] rx;

    repeat (5) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_miso", spi_miso, 1'b0);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_wr_pulse", wr_pulse_o, 1'b0);
    chk("rst_frame_err", frame_err_o, 1'b0);
    chk("rst_state", dbg_state_o, ST_IDLE);

    // write then read back
    w0 = wr_cnt;
    cs_low();
    chk("busy_in_frame", busy_o, 1'b1);
    xfer("wr_cmd", 8'h02, 8'h00);
    xfer("wr_addr", 8'h10, 8'h00);
    xfer("wr_d0", 8'hDE, 8'h00);
    xfer("wr_d1", 8'hAD, 8'h00);
    cs_high();
    chk("wr_pulses", wr_cnt - w0, 2);
    chk("busy_after", busy_o, 1'b0);

    cs_low();
    xfer("rd_cmd", 8'h03, 8'h00);
    xfer("rd_addr", 8'h10, 8'h00);
    xfer("rd_d0", 8'h00, 8'hDE);
    xfer("rd_d1", 8'h00, 8'hAD);
    cs_high();

    // pointer wrap
    cs_low();
    xfer("wrap_wcmd", 8'h02, 8'h00);
    xfer("wrap_waddr", 8'hFF, 8'h00);
    xfer("wrap_w0", 8'h11, 8'h00);
    xfer("wrap_w1", 8'h22, 8'h00);
    cs_high();
    cs_low();
    xfer("wrap_rcmd", 8'h03, 8'h00);
    xfer("wrap_raddr", 8'hFF, 8'h00);
    xfer("wrap_r0", 8'h00, 8'h11);
    xfer("wrap_r1", 8'h00, 8'h22);
    cs_high();
    cs_low();
    xfer("mem00_cmd", 8'h03, 8'h00);
    xfer("mem00_addr", 8'h00, 8'h00);
    xfer("mem00_data", 8'h00, 8'h22);
    cs_high();

    // ID and status
    cs_low();
    xfer("id_cmd", 8'h9F, 8'h00);
    xfer("id_b0", 8'h00, 8'hA5);
    xfer("id_b1", 8'h00, 8'hA5);
    cs_high();
    cs_low();
    xfer("stat1_cmd", 8'h05, 8'h00);
    xfer("stat1", 8'h00, 8'h01);
    cs_high();

    // partial byte aborts the write
    cs_low();
    xfer("pre_cmd", 8'h02, 8'h00);
    xfer("pre_addr", 8'h20, 8'h00);
    xfer("pre_data", 8'h5A, 8'h00);
    cs_high();
    w0 = wr_cnt;
    f0 = ferr_cnt;
    cs_low();
    xfer("part_cmd", 8'h02, 8'h00);
    xfer("part_addr", 8'h20, 8'h00);
    xfer_bits(8'hC3, 5, rx);
    cs_high();
    chk("part_frame_err", ferr_cnt - f0, 1);
    chk("part_no_write", wr_cnt - w0, 0);
    cs_low();
    xfer("stat_err_cmd", 8'h05, 8'h00);
    xfer("stat_err", 8'h00, 8'h03);
    cs_high();
    cs_low();
    xfer("stat_clr_cmd", 8'h05, 8'h00);
    xfer("stat_clr", 8'h00, 8'h01);
    cs_high();
    cs_low();
    xfer("mem20_cmd", 8'h03, 8'h00);
    xfer("mem20_addr", 8'h20, 8'h00);
    xfer("mem20_data", 8'h00, 8'h5A);
    cs_high();

    // unknown opcode
    w0 = wr_cnt;
    f0 = ferr_cnt;
    cs_low();
    xfer("unk_cmd", 8'h7E, 8'h00);
    xfer("unk_b0", 8'hFF, 8'h00);
    xfer("unk_b1", 8'h55, 8'h00);
    xfer("unk_b2", 8'hAA, 8'h00);
    cs_high();
    chk("unk_no_write", wr_cnt - w0, 0);
    chk("unk_no_err", ferr_cnt - f0, 0);
    chk("unk_busy_drop", busy_o, 1'b0);
    chk("unk_miso_idle", spi_miso, 1'b0);

    // seed 0x30 for the write-protect check (memory survives reset)
    cs_low();
    xfer("seed_cmd", 8'h02, 8'h00);
    xfer("seed_addr", 8'h30, 8'h00);
    xfer("seed_data", 8'h66, 8'h00);
    cs_high();

    // reset in the middle of a read
    cs_low();
    xfer("rr_cmd", 8'h03, 8'h00);
    xfer("rr_addr", 8'h10, 8'h00);
    xfer_bits(8'h00, 4, rx);
    chk("rr_partial", rx, 8'hD0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    spi_cs = 1'b1;
    repeat (4) @(negedge clk);
    chk("rr_state", dbg_state_o, ST_IDLE);
    chk("rr_busy", busy_o, 1'b0);
    chk("rr_miso", spi_miso, 1'b0);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    cs_low();
    xfer("rr_id_cmd", 8'h9F, 8'h00);
    xfer("rr_id", 8'h00, 8'hA5);
    cs_high();
    cs_low();
    xfer("rr_stat_cmd", 8'h05, 8'h00);
    xfer("rr_stat", 8'h00, 8'h00);
    cs_high();

`ifdef SPI_RAID_TARGET_WPROT_EN
    wp_i = 1'b1;
    #100;
    w0 = wr_cnt;
    cs_low();
    xfer("wp_cmd", 8'h02, 8'h00);
    xfer("wp_addr", 8'h30, 8'h00);
    xfer("wp_data", 8'h55, 8'h00);
    cs_high();
    chk("wp_no_pulse", wr_cnt - w0, 0);
    cs_low();
    xfer("wp_stat_cmd", 8'h05, 8'h00);
    xfer("wp_stat", 8'h00, 8'h04);
    cs_high();
    cs_low();
    xfer("wp_rd_cmd", 8'h03, 8'h00);
    xfer("wp_rd_addr", 8'h30, 8'h00);
    xfer("wp_rd_data", 8'h00, 8'h66);
    cs_high();
    wp_i = 1'b0;
`endif

    chk("sb_empty", exp_q.size(), 0);

    // final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
